mem_lsu: RTL and testbench
==========================

// Module: mem_lsu
// PURPOSE
//  MEM stage: sits between ex_mem and mem_wb. Non-memory ops pass straight to mem_wb.
//  Loads/stores run a req/ack data-RAM transaction with a bus timeout. The pipeline
//  is stalled via stall_req until the result is ready. Byte lanes are big-endian.
// PARAMETERS
//  TIMEOUT_CYC  16  max cycles waiting for ram_ack before abort (>=2)
// PORTS
//  clk          in   1   clock; all state updates on posedge
//  rst          in   1   asynchronous, active-high reset (`RstEnable)
//  ex_waddr     in   5   dest reg addr from ex_mem
//  ex_we        in   1   dest reg write enable from ex_mem
//  ex_wdata     in   32  ALU result (non-memory ops)
//  ex_aluop     in   8   op code; memory ops are the LB/LBU/LH/LHU/LW/SB/SH/SW `*_OP constants
//  ex_mem_addr  in   32  effective address
//  ex_st_data   in   32  store data (rt)
//  ram_rdata    in   32  read data, valid with ram_ack
//  ram_ack      in   1   one-cycle completion from RAM
//  ram_req      out  1   registered; held high until ack or timeout
//  ram_we       out  1   1=store (registered, stable while ram_req)
//  ram_addr     out  32  word address {ex_mem_addr[31:2],2'b00} (registered)
//  ram_sel      out  4   byte enables (registered)
//  ram_wdata    out  32  store data replicated to lanes (registered)
//  mem_waddr    out  5   to mem_wb
//  mem_we       out  1   to mem_wb
//  mem_wdata    out  32  to mem_wb
//  stall_req    out  1   to ctrl; freeze IF..EX/MEM regs while 1
//  addr_err     out  1   one-cycle pulse: misaligned access, no bus access made
//  bus_err      out  1   one-cycle pulse: ram_ack timeout
// BEHAVIOUR
//  Reset (async): state=IDLE, ram_req/ram_we=0, ram_addr/ram_wdata=0, ram_sel=0, cnt=0,
//   captured data=0. While rst=1: mem_we=0, mem_waddr=`NOPRegAddr, mem_wdata=0, stall_req=0.
//  States: IDLE, WAIT, DONE.
//  IDLE, non-mem op: combinational passthrough mem_*=ex_*, stall_req=0 (0-cycle latency).
//  IDLE, mem op, aligned: stall_req=1, mem_we=0; at posedge register ram_* , ram_req=1 -> WAIT.
//  Alignment: LH/LHU/SH need addr[0]=0; LW/SW need addr[1:0]=0. Misaligned in IDLE:
//   no bus access, mem_we=0, stall_req=0, addr_err=1 for that cycle, stay IDLE.
//  WAIT: stall_req=1, mem_we=0, cnt++ each cycle. ram_ack=1 -> capture ram_rdata,
//   ram_req=0 -> DONE. If cnt reaches TIMEOUT_CYC-1 without ack -> ram_req=0, bus_err
//   pulse, captured data=0 -> DONE. ram_ack outside WAIT is ignored.
//  DONE: stall_req=0; loads: mem_we=ex_we, mem_wdata=extended data; stores: mem_we=0.
//   Next posedge -> IDLE, cnt=0. Total load/store latency = 3 cycles with 1-cycle ack.
//  Lanes: addr[1:0]=0 -> sel 4'b1000 (bits 31:24) ... 3 -> 4'b0001. Half: addr[1]=0 ->
//   4'b1100. Word: 4'b1111. Store data: byte replicated x4, half x2.
//  Load extend: LB/LH sign-extend, LBU/LHU zero-extend the selected lane.
//  Reset mid-transaction: immediate abort to IDLE, ram_req=0 same cycle; no pulse outputs.
// STRUCTURE
//  defines.v: add `MemSelBus, state encodings, memory `*_OP codes if missing.
//  One sub-module: mem_lsu_align (comb.): op+addr -> ram_sel, store-lane data,
//   misaligned flag, and load lane extract/extend. FSM+counter stay in mem_lsu.
// TESTING
//  1 ADD op, ex_waddr=3, ex_wdata=0x1234 -> same cycle mem_we=1, mem_wdata=0x1234, stall_req=0.
//  2 LB addr 0x101, ack next cycle rdata=0x11F03344 -> sel 4'b0100, mem_wdata=0xFFFFFFF0,
//    stall_req high exactly 2 cycles.
//  3 SH addr 0x102, st_data=0xABCD -> ram_we=1, sel 4'b0011, wdata=0xABCDABCD, mem_we=0.
//  4 LW addr 0x6 -> addr_err 1 cycle, ram_req never asserts, mem_we=0.
//  5 LW, ram_ack never -> bus_err after TIMEOUT_CYC cycles in WAIT, mem_wdata=0, IDLE next.
//  6 rst asserted in WAIT -> ram_req=0 asynchronously, state IDLE; next LW completes normally.

Source files
------------

// File: rtl/mem_lsu_pkg.sv
// Shared definitions for the MEM-stage load/store unit: op codes, FSM states, byte-select
// width and a small decoder that classifies an ALU op as a memory access.
package mem_lsu_pkg;

  localparam int unsigned MemSelBus = 4;

  // ALU op codes seen by the MEM stage (memory ops plus the ones the pipeline passes through)
  localparam logic [7:0] EXE_NOP_OP = 8'b0000_0000;
  localparam logic [7:0] EXE_ADD_OP = 8'b0010_0000;
  localparam logic [7:0] EXE_LB_OP  = 8'b1110_0000;
  localparam logic [7:0] EXE_LH_OP  = 8'b1110_0001;
  localparam logic [7:0] EXE_LW_OP  = 8'b1110_0011;
  localparam logic [7:0] EXE_LBU_OP = 8'b1110_0100;
  localparam logic [7:0] EXE_LHU_OP = 8'b1110_0101;
  localparam logic [7:0] EXE_SB_OP  = 8'b1110_1000;
  localparam logic [7:0] EXE_SH_OP  = 8'b1110_1001;
  localparam logic [7:0] EXE_SW_OP  = 8'b1110_1011;

  localparam logic [4:0] NOP_REG_ADDR = 5'd0;

  typedef enum logic [1:0] {StIdle, StWait, StDone} lsu_state_e;

  typedef enum logic [1:0] {SzByte, SzHalf, SzWord} mem_size_e;

  typedef struct packed {
    logic      is_mem;
    logic      is_store;
    logic      is_signed;
    mem_size_e size;
  } mem_op_t;

  function automatic mem_op_t decode_mem_op(input logic [7:0] op);
    mem_op_t d;
    d.is_mem    = 1'b1;
    d.is_store  = 1'b0;
    d.is_signed = 1'b0;
    d.size      = SzWord;
    case (op)
      EXE_LB_OP:  begin d.size = SzByte; d.is_signed = 1'b1; end
      EXE_LBU_OP: d.size = SzByte;
      EXE_LH_OP:  begin d.size = SzHalf; d.is_signed = 1'b1; end
      EXE_LHU_OP: d.size = SzHalf;
      EXE_LW_OP:  d.size = SzWord;
      EXE_SB_OP:  begin d.size = SzByte; d.is_store = 1'b1; end
      EXE_SH_OP:  begin d.size = SzHalf; d.is_store = 1'b1; end
      EXE_SW_OP:  begin d.size = SzWord; d.is_store = 1'b1; end
      default:    d.is_mem = 1'b0;
    endcase
    return d;
  endfunction

endpackage

// File: rtl/mem_lsu_align.sv
// Combinational lane logic for the load/store unit (big-endian byte lanes).
// Ports:
//   aluop_i      op code from ex_mem
//   addr_lo_i    low two bits of the effective address
//   st_data_i    store data (rt)
//   rdata_i      captured load word
//   op_o         decoded op class
//   sel_o        byte enables, bit 3 = bits 31:24
//   st_lanes_o   store data replicated across the lanes
//   misaligned_o access violates natural alignment
//   ld_data_o    selected load lane, sign- or zero-extended
module mem_lsu_align
  import mem_lsu_pkg::*;
(
  input  logic [7:0]           aluop_i,
  input  logic [1:0]           addr_lo_i,
  input  logic [31:0]          st_data_i,
  input  logic [31:0]          rdata_i,
  output mem_op_t              op_o,
  output logic [MemSelBus-1:0] sel_o,
  output logic [31:0]          st_lanes_o,
  output logic                 misaligned_o,
  output logic [31:0]          ld_data_o
);

  logic [7:0]  ld_byte;
  logic [15:0] ld_half;

  always_comb begin
    op_o         = decode_mem_op(aluop_i);
    sel_o        = '0;
    st_lanes_o   = '0;
    misaligned_o = 1'b0;
    ld_data_o    = '0;

    case (addr_lo_i)
      2'd0:    ld_byte = rdata_i[31:24];
      2'd1:    ld_byte = rdata_i[23:16];
      2'd2:    ld_byte = rdata_i[15:8];
      default: ld_byte = rdata_i[7:0];
    endcase
    ld_half = addr_lo_i[1] ? rdata_i[15:0] : rdata_i[31:16];

    case (op_o.size)
      SzByte: begin
        sel_o      = 4'b1000 >> addr_lo_i;
        st_lanes_o = {4{st_data_i[7:0]}};
        ld_data_o  = {{24{op_o.is_signed & ld_byte[7]}}, ld_byte};
      end
      SzHalf: begin
        sel_o        = addr_lo_i[1] ? 4'b0011 : 4'b1100;
        st_lanes_o   = {2{st_data_i[15:0]}};
        misaligned_o = addr_lo_i[0];
        ld_data_o    = {{16{op_o.is_signed & ld_half[15]}}, ld_half};
      end
      default: begin
        sel_o        = 4'b1111;
        st_lanes_o   = st_data_i;
        misaligned_o = |addr_lo_i;
        ld_data_o    = rdata_i;
      end
    endcase

    if (!op_o.is_mem) misaligned_o = 1'b0;
  end

endmodule

// File: rtl/mem_lsu.sv
// MEM stage load/store unit between ex_mem and mem_wb. Non-memory ops pass straight through;
// loads/stores run one req/ack transaction on the data RAM with a timeout, stalling the
// pipeline until the result is ready.
// Ports:
//   clk, rst            clock, asynchronous active-high reset
//   ex_*                stage inputs from ex_mem (held stable by the stall)
//   ram_rdata, ram_ack  RAM response
//   ram_*               registered RAM request
//   mem_*               result to mem_wb
//   stall_req           freeze request to ctrl
//   addr_err, bus_err   one-cycle error pulses
module mem_lsu
  import mem_lsu_pkg::*;
#(
  parameter int unsigned TIMEOUT_CYC = 16
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [4:0]           ex_waddr,
  input  logic                 ex_we,
  input  logic [31:0]          ex_wdata,
  input  logic [7:0]           ex_aluop,
  input  logic [31:0]          ex_mem_addr,
  input  logic [31:0]          ex_st_data,
  input  logic [31:0]          ram_rdata,
  input  logic                 ram_ack,
  output logic                 ram_req,
  output logic                 ram_we,
  output logic [31:0]          ram_addr,
  output logic [MemSelBus-1:0] ram_sel,
  output logic [31:0]          ram_wdata,
  output logic [4:0]           mem_waddr,
  output logic                 mem_we,
  output logic [31:0]          mem_wdata,
  output logic                 stall_req,
  output logic                 addr_err,
  output logic                 bus_err
);

  localparam int unsigned CntW = (TIMEOUT_CYC > 2) ? $clog2(TIMEOUT_CYC) : 1;
  localparam logic [CntW-1:0] CntLast = CntW'(TIMEOUT_CYC - 1);

  lsu_state_e state_q, state_d;
  logic [CntW-1:0] cnt_q, cnt_d;
  logic ram_req_q, ram_req_d;
  logic ram_we_q, ram_we_d;
  logic [31:0] ram_addr_q, ram_addr_d;
  logic [MemSelBus-1:0] ram_sel_q, ram_sel_d;
  logic [31:0] ram_wdata_q, ram_wdata_d;
  logic [31:0] rdata_q, rdata_d;

  mem_op_t op;
  logic [MemSelBus-1:0] sel;
  logic [31:0] st_lanes;
  logic misaligned;
  logic [31:0] ld_data;

  logic [4:0]  mem_waddr_c;
  logic        mem_we_c;
  logic [31:0] mem_wdata_c;
  logic        stall_c;
  logic        addr_err_c;
  logic        bus_err_c;

  mem_lsu_align u_align (
    .aluop_i      (ex_aluop),
    .addr_lo_i    (ex_mem_addr[1:0]),
    .st_data_i    (ex_st_data),
    .rdata_i      (rdata_q),
    .op_o         (op),
    .sel_o        (sel),
    .st_lanes_o   (st_lanes),
    .misaligned_o (misaligned),
    .ld_data_o    (ld_data)
  );

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    ram_req_d   = ram_req_q;
    ram_we_d    = ram_we_q;
    ram_addr_d  = ram_addr_q;
    ram_sel_d   = ram_sel_q;
    ram_wdata_d = ram_wdata_q;
    rdata_d     = rdata_q;
    mem_waddr_c = ex_waddr;
    mem_we_c    = 1'b0;
    mem_wdata_c = '0;
    stall_c     = 1'b0;
    addr_err_c  = 1'b0;
    bus_err_c   = 1'b0;

    case (state_q)
      StIdle: begin
        if (!op.is_mem) begin
          mem_we_c    = ex_we;
          mem_wdata_c = ex_wdata;
        end else if (misaligned) begin
          addr_err_c = 1'b1;
        end else begin
          stall_c     = 1'b1;
          ram_req_d   = 1'b1;
          ram_we_d    = op.is_store;
          ram_addr_d  = {ex_mem_addr[31:2], 2'b00};
          ram_sel_d   = sel;
          ram_wdata_d = st_lanes;
          rdata_d     = '0;
          cnt_d       = '0;
          state_d     = StWait;
        end
      end
      StWait: begin
        stall_c = 1'b1;
        cnt_d   = cnt_q + CntW'(1);
        if (ram_ack) begin
          rdata_d   = ram_rdata;
          ram_req_d = 1'b0;
          state_d   = StDone;
        end else if (cnt_q == CntLast) begin
          // Abort: a timed-out load returns zero rather than stale bus data
          rdata_d   = '0;
          ram_req_d = 1'b0;
          bus_err_c = 1'b1;
          state_d   = StDone;
        end
      end
      StDone: begin
        if (!op.is_store) begin
          mem_we_c    = ex_we;
          mem_wdata_c = ld_data;
        end
        cnt_d   = '0;
        state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= StIdle;
      cnt_q       <= '0;
      ram_req_q   <= 1'b0;
      ram_we_q    <= 1'b0;
      ram_addr_q  <= '0;
      ram_sel_q   <= '0;
      ram_wdata_q <= '0;
      rdata_q     <= '0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      ram_req_q   <= ram_req_d;
      ram_we_q    <= ram_we_d;
      ram_addr_q  <= ram_addr_d;
      ram_sel_q   <= ram_sel_d;
      ram_wdata_q <= ram_wdata_d;
      rdata_q     <= rdata_d;
    end
  end

  assign ram_req   = ram_req_q;
  assign ram_we    = ram_we_q;
  assign ram_addr  = ram_addr_q;
  assign ram_sel   = ram_sel_q;
  assign ram_wdata = ram_wdata_q;

  // The passthrough path is combinational, so reset has to mask it explicitly
  assign mem_waddr = rst ? NOP_REG_ADDR : mem_waddr_c;
  assign mem_we    = rst ? 1'b0 : mem_we_c;
  assign mem_wdata = rst ? 32'd0 : mem_wdata_c;
  assign stall_req = rst ? 1'b0 : stall_c;
  assign addr_err  = rst ? 1'b0 : addr_err_c;
  assign bus_err   = rst ? 1'b0 : bus_err_c;

endmodule

// File: tb/tb_mem_lsu.sv
// Directed bench for mem_lsu: passthrough, load lanes/extension, stores, misalignment,
// bus timeout and reset during a transaction.
module tb_mem_lsu;
  import mem_lsu_pkg::*;

  localparam int unsigned TimeoutCyc = 16;

  logic        clk = 1'b0;
  logic        rst;
  logic [4:0]  ex_waddr;
  logic        ex_we;
  logic [31:0] ex_wdata;
  logic [7:0]  ex_aluop;
  logic [31:0] ex_mem_addr;
  logic [31:0] ex_st_data;
  logic [31:0] ram_rdata;
  logic        ram_ack;
  logic        ram_req;
  logic        ram_we;
  logic [31:0] ram_addr;
  logic [3:0]  ram_sel;
  logic [31:0] ram_wdata;
  logic [4:0]  mem_waddr;
  logic        mem_we;
  logic [31:0] mem_wdata;
  logic        stall_req;
  logic        addr_err;
  logic        bus_err;

  int n_cmp = 0;
  int n_err = 0;

  logic [7:0]  ld_op  [6];
  logic [31:0] ld_adr [6];
  logic [31:0] ld_rd  [6];
  logic [3:0]  ld_sel [6];
  logic [31:0] ld_exp [6];

  mem_lsu #(.TIMEOUT_CYC(TimeoutCyc)) dut (
    .clk         (clk),
    .rst         (rst),
    .ex_waddr    (ex_waddr),
    .ex_we       (ex_we),
    .ex_wdata    (ex_wdata),
    .ex_aluop    (ex_aluop),
    .ex_mem_addr (ex_mem_addr),
    .ex_st_data  (ex_st_data),
    .ram_rdata   (ram_rdata),
    .ram_ack     (ram_ack),
    .ram_req     (ram_req),
    .ram_we      (ram_we),
    .ram_addr    (ram_addr),
    .ram_sel     (ram_sel),
    .ram_wdata   (ram_wdata),
    .mem_waddr   (mem_waddr),
    .mem_we      (mem_we),
    .mem_wdata   (mem_wdata),
    .stall_req   (stall_req),
    .addr_err    (addr_err),
    .bus_err     (bus_err)
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive_nop();
    ex_aluop    = EXE_NOP_OP;
    ex_we       = 1'b0;
    ex_waddr    = 5'd0;
    ex_wdata    = 32'd0;
    ex_mem_addr = 32'd0;
    ex_st_data  = 32'd0;
    ram_ack     = 1'b0;
    ram_rdata   = 32'd0;
  endtask

  task automatic test_reset();
    ex_aluop = EXE_ADD_OP; ex_we = 1'b1; ex_waddr = 5'd9; ex_wdata = 32'h55;
    #1;
    n_cmp++; if (mem_we !== 1'b0) begin n_err++;
      $display("FAIL rst_mem_we: got %b want 0", mem_we); end
    n_cmp++; if (mem_waddr !== 5'd0) begin n_err++;
      $display("FAIL rst_mem_waddr: got %0d want 0", mem_waddr); end
    n_cmp++; if (mem_wdata !== 32'd0) begin n_err++;
      $display("FAIL rst_mem_wdata: got %h want 0", mem_wdata); end
    n_cmp++; if (stall_req !== 1'b0) begin n_err++;
      $display("FAIL rst_stall: got %b want 0", stall_req); end
    n_cmp++; if ({ram_req, ram_we, ram_sel} !== 6'd0) begin n_err++;
      $display("FAIL rst_ram_ctl: got %b want 0", {ram_req, ram_we, ram_sel}); end
    n_cmp++; if ({ram_addr, ram_wdata} !== 64'd0) begin n_err++;
      $display("FAIL rst_ram_data: got %h want 0", {ram_addr, ram_wdata}); end
    rst = 1'b0;
    drive_nop();
    step();
  endtask

  task automatic test_passthrough();
    ex_aluop = EXE_ADD_OP; ex_we = 1'b1; ex_waddr = 5'd3; ex_wdata = 32'h1234;
    ram_ack = 1'b1; // stray ack in IDLE must be ignored
    #1;
    n_cmp++; if ({mem_we, mem_waddr, mem_wdata} !== {1'b1, 5'd3, 32'h1234}) begin n_err++;
      $display("FAIL pass_out: got we=%b wa=%0d wd=%h want 1/3/00001234",
               mem_we, mem_waddr, mem_wdata); end
    n_cmp++; if (stall_req !== 1'b0) begin n_err++;
      $display("FAIL pass_stall: got %b want 0", stall_req); end
    step();
    n_cmp++; if ({ram_req, stall_req} !== 2'b00) begin n_err++;
      $display("FAIL pass_stray_ack: got req/stall %b want 00", {ram_req, stall_req}); end
    drive_nop();
  endtask

  task automatic test_lb();
    int stalls = 0;
    ex_aluop = EXE_LB_OP; ex_we = 1'b1; ex_waddr = 5'd5; ex_mem_addr = 32'h101;
    #1;
    if (stall_req === 1'b1) stalls++;
    n_cmp++; if ({mem_we, ram_req} !== 2'b00) begin n_err++;
      $display("FAIL lb_idle: got we/req %b want 00", {mem_we, ram_req}); end
    step();
    if (stall_req === 1'b1) stalls++;
    n_cmp++; if ({ram_req, ram_we, ram_sel} !== 6'b10_0100) begin n_err++;
      $display("FAIL lb_req: got req/we/sel %b want 100100", {ram_req, ram_we, ram_sel}); end
    n_cmp++; if (ram_addr !== 32'h100) begin n_err++;
      $display("FAIL lb_addr: got %h want 00000100", ram_addr); end
    ram_ack = 1'b1; ram_rdata = 32'h11F0_3344;
    step();
    ram_ack = 1'b0;
    #1;
    if (stall_req === 1'b1) stalls++;
    n_cmp++; if ({mem_we, mem_waddr, mem_wdata} !== {1'b1, 5'd5, 32'hFFFF_FFF0}) begin
      n_err++;
      $display("FAIL lb_result: got we=%b wa=%0d wd=%h want 1/5/fffffff0",
               mem_we, mem_waddr, mem_wdata); end
    n_cmp++; if (ram_req !== 1'b0) begin n_err++;
      $display("FAIL lb_req_drop: got %b want 0", ram_req); end
    n_cmp++; if (stalls != 2) begin n_err++;
      $display("FAIL lb_stall_cycles: got %0d want 2", stalls); end
    drive_nop();
    step();
  endtask

  task automatic test_load_lanes();
    ld_op  = '{EXE_LB_OP, EXE_LBU_OP, EXE_LBU_OP, EXE_LH_OP, EXE_LHU_OP, EXE_LW_OP};
    ld_adr = '{32'h0, 32'h3, 32'h2, 32'h0, 32'h2, 32'h4};
    ld_rd  = '{32'h7F12_3456, 32'h0000_00F0, 32'h0000_AB00, 32'h8001_1234,
               32'h1234_8765, 32'hCAFE_F00D};
    ld_sel = '{4'b1000, 4'b0001, 4'b0010, 4'b1100, 4'b0011, 4'b1111};
    ld_exp = '{32'h0000_007F, 32'h0000_00F0, 32'h0000_00AB, 32'hFFFF_8001,
               32'h0000_8765, 32'hCAFE_F00D};
    for (int i = 0; i < 6; i++) begin
      ex_aluop = ld_op[i]; ex_we = 1'b1; ex_waddr = 5'(i + 8); ex_mem_addr = ld_adr[i];
      #1;
      step();
      n_cmp++; if (ram_sel !== ld_sel[i] || ram_addr !== {ld_adr[i][31:2], 2'b00}) begin
        n_err++;
        $display("FAIL lane_req[%0d]: got sel=%b addr=%h want sel=%b", i, ram_sel, ram_addr,
                 ld_sel[i]); end
      ram_ack = 1'b1; ram_rdata = ld_rd[i];
      step();
      ram_ack = 1'b0;
      #1;
      n_cmp++; if (mem_wdata !== ld_exp[i] || mem_we !== 1'b1) begin n_err++;
        $display("FAIL lane_data[%0d]: got %h we=%b want %h we=1", i, mem_wdata, mem_we,
                 ld_exp[i]); end
      drive_nop();
      step();
    end
  endtask

  task automatic test_stores();
    ex_aluop = EXE_SH_OP; ex_we = 1'b0; ex_mem_addr = 32'h102; ex_st_data = 32'h0000_ABCD;
    #1;
    step();
    n_cmp++; if ({ram_req, ram_we, ram_sel} !== 6'b11_0011) begin n_err++;
      $display("FAIL sh_req: got req/we/sel %b want 110011", {ram_req, ram_we, ram_sel}); end
    n_cmp++; if (ram_wdata !== 32'hABCD_ABCD) begin n_err++;
      $display("FAIL sh_wdata: got %h want abcdabcd", ram_wdata); end
    ram_ack = 1'b1;
    step();
    ram_ack = 1'b0;
    #1;
    n_cmp++; if ({mem_we, stall_req} !== 2'b00) begin n_err++;
      $display("FAIL sh_done: got we/stall %b want 00", {mem_we, stall_req}); end
    drive_nop();
    step();
    // SB with ex_we set: stores must still never write back
    ex_aluop = EXE_SB_OP; ex_we = 1'b1; ex_mem_addr = 32'h203; ex_st_data = 32'h1234_565A;
    #1;
    step();
    n_cmp++; if (ram_sel !== 4'b0001 || ram_wdata !== 32'h5A5A_5A5A) begin n_err++;
      $display("FAIL sb_req: got sel=%b wd=%h want 0001/5a5a5a5a", ram_sel, ram_wdata); end
    ram_ack = 1'b1;
    step();
    ram_ack = 1'b0;
    #1;
    n_cmp++; if (mem_we !== 1'b0) begin n_err++;
      $display("FAIL sb_mem_we: got %b want 0", mem_we); end
    drive_nop();
    step();
  endtask

  task automatic test_misaligned();
    ex_aluop = EXE_LW_OP; ex_we = 1'b1; ex_waddr = 5'd4; ex_mem_addr = 32'h6;
    #1;
    n_cmp++; if ({addr_err, stall_req, mem_we} !== 3'b100) begin n_err++;
      $display("FAIL mis_pulse: got err/stall/we %b want 100", {addr_err, stall_req, mem_we});
    end
    step();
    n_cmp++; if (ram_req !== 1'b0) begin n_err++;
      $display("FAIL mis_no_req: got %b want 0", ram_req); end
    ex_aluop = EXE_ADD_OP;
    #1;
    n_cmp++; if ({addr_err, mem_we} !== 2'b01) begin n_err++;
      $display("FAIL mis_after: got err/we %b want 01", {addr_err, mem_we}); end
    drive_nop();
    step();
  endtask

  task automatic test_timeout();
    int waited = 0;
    logic seen = 1'b0;
    ex_aluop = EXE_LW_OP; ex_we = 1'b1; ex_waddr = 5'd7; ex_mem_addr = 32'h200;
    #1;
    step();
    for (int i = 0; i < 40 && !seen; i++) begin
      waited++;
      if (bus_err === 1'b1) seen = 1'b1;
      else step();
    end
    n_cmp++; if (!seen || waited != TimeoutCyc) begin n_err++;
      $display("FAIL to_cycles: got seen=%b after %0d want %0d", seen, waited, TimeoutCyc);
    end
    n_cmp++; if ({ram_req, stall_req} !== 2'b11) begin n_err++;
      $display("FAIL to_last_wait: got req/stall %b want 11", {ram_req, stall_req}); end
    step();
    n_cmp++; if ({bus_err, ram_req, stall_req} !== 3'b000 || mem_wdata !== 32'd0) begin
      n_err++;
      $display("FAIL to_done: got err/req/stall %b wd=%h want 000/0",
               {bus_err, ram_req, stall_req}, mem_wdata); end
    ex_aluop = EXE_ADD_OP; ex_wdata = 32'h77;
    step();
    n_cmp++; if ({mem_we, stall_req} !== 2'b10 || mem_wdata !== 32'h77) begin n_err++;
      $display("FAIL to_idle: got we/stall %b wd=%h want 10/77", {mem_we, stall_req},
               mem_wdata); end
    drive_nop();
    step();
  endtask

  task automatic test_reset_mid();
    ex_aluop = EXE_LW_OP; ex_we = 1'b1; ex_waddr = 5'd2; ex_mem_addr = 32'h300;
    #1;
    step();
    n_cmp++; if (ram_req !== 1'b1) begin n_err++;
      $display("FAIL rm_req_before: got %b want 1", ram_req); end
    rst = 1'b1;
    #1;
    n_cmp++; if ({ram_req, stall_req, mem_we, bus_err, addr_err} !== 5'd0) begin n_err++;
      $display("FAIL rm_abort: got %b want 00000",
               {ram_req, stall_req, mem_we, bus_err, addr_err}); end
    rst = 1'b0;
    #1;
    n_cmp++; if ({stall_req, ram_req} !== 2'b10) begin n_err++;
      $display("FAIL rm_idle: got stall/req %b want 10", {stall_req, ram_req}); end
    step();
    ram_ack = 1'b1; ram_rdata = 32'hDEAD_BEEF;
    step();
    ram_ack = 1'b0;
    #1;
    n_cmp++; if ({mem_we, mem_waddr, mem_wdata} !== {1'b1, 5'd2, 32'hDEAD_BEEF}) begin
      n_err++;
      $display("FAIL rm_reload: got we=%b wa=%0d wd=%h want 1/2/deadbeef",
               mem_we, mem_waddr, mem_wdata); end
    drive_nop();
    step();
  endtask

  initial begin
    rst = 1'b1;
    drive_nop();
    repeat (2) @(posedge clk);
    #3;
    test_reset();
    test_passthrough();
    test_lb();
    test_load_lanes();
    test_stores();
    test_misaligned();
    test_timeout();
    test_reset_mid();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
